// File: rtl/vedic_multiplier_pipe_if.sv
// Operand/result handshake bundle for the pipelined Vedic multiplier.
// master drives operands and consumes results; slave is the multiplier side.
interface vedic_multiplier_pipe_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24
);
   logic                  inValid;
   logic                  inReady;
   logic [DATA_WIDTH-1:0] inData_A;
   logic [DATA_WIDTH-1:0] inData_B;
   logic                  inSigned;
   logic                  inAcc;
   logic                  outValid;
   logic                  outReady;
   logic [ACC_WIDTH-1:0]  outData_C;

   modport master (
      output inValid, inData_A, inData_B, inSigned, inAcc, outReady,
      input  inReady, outValid, outData_C
   );

   modport slave (
      input  inValid, inData_A, inData_B, inSigned, inAcc, outReady,
      output inReady, outValid, outData_C
   );
endinterface

// File: rtl/vedic_multiplier_pipe.sv
// Pipelined Vedic multiplier/accumulator: S0 magnitudes, S1 half-width partial
// products, then recombine, sign, extend and accumulate into outData_C.
module vedic_mul #(
   parameter int W = 4
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);
   generate
      if (W == 2) begin : g_leaf
         // 2x2 crosswise: vertical, crosswise, vertical with the cross carry
         logic t0, t1, c1, hv;
         assign t0 = a[1] & b[0];
         assign t1 = a[0] & b[1];
         assign c1 = t0 & t1;
         assign hv = a[1] & b[1];
         assign p  = {hv & c1, hv ^ c1, t0 ^ t1, a[0] & b[0]};
      end else begin : g_split
         localparam int H = W / 2;
         logic [W-1:0] ll, lh, hl, hh;
         logic [W:0]   mid;
         vedic_mul #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
         vedic_mul #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
         vedic_mul #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
         vedic_mul #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));
         assign mid = {1'b0, lh} + {1'b0, hl};
         assign p   = {hh, ll} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
      end
   endgenerate
endmodule

module vedic_multiplier_pipe #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_GUARD  = 8
) (
   input logic                    clk,
   input logic                    rst_n,
   vedic_multiplier_pipe_if.slave bus
);
   localparam int ACC_WIDTH = 2*DATA_WIDTH + ACC_GUARD;
   localparam int HW        = DATA_WIDTH / 2;
   localparam int PW        = 2*DATA_WIDTH;
   localparam int STAGES    = 2;

   logic [STAGES:0] vld_pipe_q;
   logic            adv;

   // No skid buffer: a stalled output freezes every stage.
   assign adv          = !vld_pipe_q[STAGES] || bus.outReady;
   assign bus.inReady  = adv;
   assign bus.outValid = vld_pipe_q[STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe_q <= '0;
      else if (adv) vld_pipe_q <= {vld_pipe_q[STAGES-1:0], bus.inValid};
   end

   // S0: magnitudes; -2^(DW-1) maps to 2^(DW-1), which still fits unsigned.
   logic [DATA_WIDTH-1:0] mag_a_d, mag_b_d, mag_a_q, mag_b_q;
   logic                  neg0_q, sgn0_q, acc0_q;

   always_comb begin
      mag_a_d = (bus.inSigned && bus.inData_A[DATA_WIDTH-1]) ? -bus.inData_A : bus.inData_A;
      mag_b_d = (bus.inSigned && bus.inData_B[DATA_WIDTH-1]) ? -bus.inData_B : bus.inData_B;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_a_q <= '0;
         mag_b_q <= '0;
         neg0_q  <= 1'b0;
         sgn0_q  <= 1'b0;
         acc0_q  <= 1'b0;
      end else if (adv && bus.inValid) begin
         mag_a_q <= mag_a_d;
         mag_b_q <= mag_b_d;
         neg0_q  <= bus.inSigned & (bus.inData_A[DATA_WIDTH-1] ^ bus.inData_B[DATA_WIDTH-1]);
         sgn0_q  <= bus.inSigned;
         acc0_q  <= bus.inAcc;
      end
   end

   // S1: four half-width Vedic partial products
   logic [DATA_WIDTH-1:0] hh_d, lh_d, hl_d, ll_d;
   logic [DATA_WIDTH-1:0] hh_q, lh_q, hl_q, ll_q;
   logic                  neg1_q, sgn1_q, acc1_q;

   vedic_mul #(.W(HW)) u_ll (.a(mag_a_q[HW-1:0]),          .b(mag_b_q[HW-1:0]),          .p(ll_d));
   vedic_mul #(.W(HW)) u_lh (.a(mag_a_q[HW-1:0]),          .b(mag_b_q[DATA_WIDTH-1:HW]), .p(lh_d));
   vedic_mul #(.W(HW)) u_hl (.a(mag_a_q[DATA_WIDTH-1:HW]), .b(mag_b_q[HW-1:0]),          .p(hl_d));
   vedic_mul #(.W(HW)) u_hh (.a(mag_a_q[DATA_WIDTH-1:HW]), .b(mag_b_q[DATA_WIDTH-1:HW]), .p(hh_d));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hh_q   <= '0;
         lh_q   <= '0;
         hl_q   <= '0;
         ll_q   <= '0;
         neg1_q <= 1'b0;
         sgn1_q <= 1'b0;
         acc1_q <= 1'b0;
      end else if (adv && vld_pipe_q[0]) begin
         hh_q   <= hh_d;
         lh_q   <= lh_d;
         hl_q   <= hl_d;
         ll_q   <= ll_d;
         neg1_q <= neg0_q;
         sgn1_q <= sgn0_q;
         acc1_q <= acc0_q;
      end
   end

   // S2: recombine, apply sign, extend per this beat's own signedness, accumulate
   logic [DATA_WIDTH:0]  mid;
   logic [PW-1:0]        prod, prod_s;
   logic [ACC_WIDTH-1:0] ext, out_d, out_q;

   always_comb begin
      mid    = {1'b0, lh_q} + {1'b0, hl_q};
      prod   = {hh_q, ll_q} + {{(HW-1){1'b0}}, mid, {HW{1'b0}}};
      prod_s = neg1_q ? -prod : prod;
      ext    = '0;
      ext[PW-1:0] = prod_s;
      for (int i = PW; i < ACC_WIDTH; i++) ext[i] = sgn1_q & prod_s[PW-1];
      out_d  = acc1_q ? out_q + ext : ext;
   end

   // outData_C doubles as the accumulator; bubbles leave it untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_q <= '0;
      else if (adv && vld_pipe_q[STAGES-1]) out_q <= out_d;
   end

   assign bus.outData_C = out_q;
endmodule

// File: tb/tb_vedic_multiplier_pipe.sv
// Scoreboard bench: four multiplier instances (8/8-guard, 8/no-guard, 4, 16 bit)
// driven by directed and random beats; one negedge monitor checks all outputs.
module tb_vedic_multiplier_pipe;
  typedef struct {
    longint unsigned exp;
    int              cyc;
    bit              lat;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            drv_v[4], drv_s[4], drv_acc[4], drv_ordy[4];
  logic [31:0]     drv_a[4], drv_b[4];
  bit              drv_use[4];
  longint unsigned drv_exp[4];
  logic            rdy[4], ovld[4];
  logic [63:0]     odata[4];

  sb_t             sbq[4][$];
  longint unsigned macc[4];
  int n_cmp = 0, n_err = 0, cyc = 0, tmo = 0;
  bit lat_chk = 1'b0, fin = 1'b0, fin_done = 1'b0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DW = (g == 2) ? 4 : (g == 3) ? 16 : 8;
    localparam int AG = (g == 1) ? 0 : 8;
    vedic_multiplier_pipe_if #(.DATA_WIDTH(DW), .ACC_WIDTH(2*DW+AG)) bus ();
    assign bus.inValid  = drv_v[g];
    assign bus.inData_A = drv_a[g][DW-1:0];
    assign bus.inData_B = drv_b[g][DW-1:0];
    assign bus.inSigned = drv_s[g];
    assign bus.inAcc    = drv_acc[g];
    assign bus.outReady = drv_ordy[g];
    assign rdy[g]   = bus.inReady;
    assign ovld[g]  = bus.outValid;
    assign odata[g] = 64'(bus.outData_C);
    vedic_multiplier_pipe #(.DATA_WIDTH(DW), .ACC_GUARD(AG)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
  end

  function automatic int dw_of(int k);
    return (k == 2) ? 4 : (k == 3) ? 16 : 8;
  endfunction
  function automatic int aw_of(int k);
    return 2*dw_of(k) + ((k == 1) ? 0 : 8);
  endfunction
  function automatic longint unsigned msk(int aw);
    return (64'd1 << aw) - 64'd1;
  endfunction
  // reference: plain integer product, masked to the accumulator width
  function automatic longint unsigned prod(int k, logic [31:0] a, logic [31:0] b, bit s);
    int dw = dw_of(k);
    longint m = (longint'(1) << dw) - 1;
    longint sa = longint'({32'd0, a}) & m;
    longint sb = longint'({32'd0, b}) & m;
    if (s && sa[dw-1]) sa -= (longint'(1) << dw);
    if (s && sb[dw-1]) sb -= (longint'(1) << dw);
    return longint'(sa * sb) & msk(aw_of(k));
  endfunction

  always @(negedge clk) begin
    sb_t e;
    longint unsigned p;
    cyc++;
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        sbq[k].delete();
        macc[k] = 0;
        n_cmp++;
        if (ovld[k] !== 1'b0 || odata[k] !== 64'd0) begin
          n_err++;
          $display("FAIL reset_state dut%0d: got valid=%b data=%h, want valid=0 data=0", k, ovld[k], odata[k]);
        end
      end else begin
        if (ovld[k] && drv_ordy[k]) begin
          n_cmp++;
          if (sbq[k].size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output dut%0d: got data=%h, want no output", k, odata[k]);
          end else begin
            e = sbq[k].pop_front();
            if (odata[k] !== e.exp) begin
              n_err++;
              $display("FAIL result dut%0d: got %h, want %h", k, odata[k], e.exp);
            end
            if (e.lat) begin
              n_cmp++;
              if (cyc - e.cyc != 3) begin
                n_err++;
                $display("FAIL latency dut%0d: got %0d cycles, want 3", k, cyc - e.cyc);
              end
            end
          end
        end
        if (ovld[k] && !drv_ordy[k]) begin
          n_cmp++;
          if (rdy[k] !== 1'b0) begin
            n_err++;
            $display("FAIL stall_ready dut%0d: got inReady=%b, want 0", k, rdy[k]);
          end
        end
        if (drv_v[k] && rdy[k]) begin
          if (drv_use[k]) p = drv_exp[k];
          else p = drv_acc[k] ? ((macc[k] + prod(k, drv_a[k], drv_b[k], drv_s[k])) & msk(aw_of(k)))
                              : prod(k, drv_a[k], drv_b[k], drv_s[k]);
          macc[k] = p;
          e.exp = p;
          e.cyc = cyc;
          e.lat = lat_chk;
          sbq[k].push_back(e);
        end
      end
    end
    if (fin && !fin_done) begin
      fin_done = 1'b1;
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (sbq[k].size() != 0) begin
          n_err++;
          $display("FAIL drain dut%0d: got %0d pending, want 0", k, sbq[k].size());
        end
      end
      n_cmp++;
      if (tmo != 0) begin
        n_err++;
        $display("FAIL accept_timeout: got %0d stuck beats, want 0", tmo);
      end
    end
  end

  // inputs change 1 time unit after the rising edge; accept is judged at negedge
  task automatic drive(input int k, input logic [31:0] a, input logic [31:0] b,
                       input bit s, input bit ac, input bit use_e, input longint unsigned e);
    bit got = 1'b0;
    int t = 0;
    drv_a[k] = a; drv_b[k] = b; drv_s[k] = s; drv_acc[k] = ac;
    drv_use[k] = use_e; drv_exp[k] = e; drv_v[k] = 1'b1;
    while (!got && t < 50) begin
      @(negedge clk);
      got = rdy[k];
      @(posedge clk);
      #1;
      t++;
    end
    if (!got) tmo++;
    drv_v[k] = 1'b0;
  endtask

  task automatic rnd(input int k, input int n);
    for (int i = 0; i < n; i++)
      drive(k, $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      drv_v[k] = 1'b0; drv_a[k] = '0; drv_b[k] = '0; drv_s[k] = 1'b0;
      drv_acc[k] = 1'b0; drv_ordy[k] = 1'b1; drv_use[k] = 1'b0; drv_exp[k] = 0;
    end
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // 8-bit, 24-bit accumulator: directed
    lat_chk = 1'b1;
    drive(0, 255, 255, 0, 0, 1, 64'h00FE01);
    lat_chk = 1'b0;
    drive(0, 'h80, 'h80, 1, 0, 1, 64'h004000);
    drive(0, 'h80, 'h7F, 1, 0, 1, 64'hFFC080);
    drive(0, 3, 4, 0, 0, 1, 64'd12);
    drive(0, 5, 6, 0, 1, 1, 64'd42);
    drive(0, 'hFE, 7, 1, 1, 1, 64'd28);
    drive(0, 'hFF, 1, 1, 1, 1, 64'd27);
    drive(0, 'h7F, 'h7F, 1, 0, 1, 64'h003F01);
    idle(5);

    // back-pressure in the middle of a stream
    fork
      rnd(0, 6);
      begin
        idle(4);
        drv_ordy[0] = 1'b0;
        idle(4);
        drv_ordy[0] = 1'b1;
      end
    join
    idle(6);

    // reset with the accumulator at 500 and beats in flight
    drive(0, 20, 25, 0, 0, 1, 64'd500);
    drive(0, 1, 1, 0, 1, 1, 64'd501);
    drive(0, 1, 1, 0, 1, 1, 64'd502);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    drive(0, 2, 3, 0, 1, 1, 64'd6);

    // no guard bits: silent modulo-2^16 wrap
    drive(1, 255, 255, 0, 0, 1, 64'hFE01);
    drive(1, 255, 255, 0, 1, 1, 64'hFC02);
    drive(1, 255, 255, 0, 1, 1, 64'hFA03);

    // 4-bit
    drive(2, 'h8, 'h8, 1, 0, 1, 64'h0040);
    drive(2, 'h8, 'h7, 1, 0, 1, 64'hFFC8);
    drive(2, 'hF, 'hF, 0, 0, 1, 64'h00E1);
    rnd(2, 20);

    // 16-bit
    drive(3, 'hFFFF, 'hFFFF, 0, 0, 1, 64'h00FFFE0001);
    drive(3, 'h8000, 'h8000, 1, 0, 1, 64'h0040000000);
    fork
      rnd(3, 20);
      begin
        repeat (30) begin
          idle(1);
          drv_ordy[3] = 1'($urandom_range(1));
        end
        drv_ordy[3] = 1'b1;
      end
    join

    rnd(0, 20);
    idle(12);
    fin = 1'b1;
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
